apb_requester: RTL and testbench
================================

# apb_requester

Single-outstanding APB4 requester that turns a simple command/response handshake into APB transfers. It owns PSEL, PENABLE and the address, control and write-data signals on the requester side of the APB bus, and drives one peripheral slot. It handles wait states, PSLVERR capture, back-to-back chaining and a programmable ACCESS-phase timeout. It sits between the test/sequencer logic and the APB peripherals.

## Interface
- ADDR_WIDTH, 32, PADDR width in bits.
- DATA_WIDTH, 32, PWDATA/PRDATA width in bits. Must be a multiple of 8.
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width in bits.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort. Range 0..255; 0 disables the timeout.
- pclk  input  1  APB clock. Every register updates on its rising edge.
- presetn  input  1  Reset. Asynchronous assertion, active-low.
- cmd_valid  input  1  Command present.
- cmd_ready  output  1  Command accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  Transfer address.
- cmd_wdata  input  DATA_WIDTH  Write data.
- cmd_strb  input  STRB_WIDTH  Write byte enables; 1 = lane written.
- cmd_prot  input  3  PPROT value for the transfer.
- rsp_valid  output  1  One-cycle pulse; the transfer has completed.
- rsp_rdata  output  DATA_WIDTH  Read data. Valid only when rsp_valid is high and the transfer was a read.
- rsp_err  output  1  PSLVERR was returned, or the transfer timed out.
- rsp_timeout  output  1  The transfer was aborted by the timeout.
- psel, penable, pwrite  output  1 each  APB control.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pstrb  output  STRB_WIDTH  APB write strobes.
- pprot  output  3  APB protection.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB error.

## Operation
- **States**
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- **IDLE**
  - cmd_ready = 1, forced to 0 while presetn is low.
  - On acceptance: latch the command into paddr, pwrite, pprot, pwdata and pstrb, then go to SETUP.
  - For reads, pwdata and pstrb are driven 0.
- **SETUP** always advances to ACCESS after exactly one cycle. pready is ignored in SETUP.
- **ACCESS** holds every APB output stable until pready = 1 is sampled.
  - On completion, capture prdata (reads only; writes return 0), pslverr and rsp_timeout = 0, and pulse rsp_valid on the next cycle.
  - cmd_ready = pready, combinationally. This allows chaining.
  - If a command is accepted on the completion edge: go to SETUP, keep psel high, deassert penable and load the new fields.
  - Otherwise: go to IDLE with psel = 0.
  - pslverr is sampled only when pready = 1 in ACCESS.
- **Timeout** (TIMEOUT > 0)
  - An 8-bit counter clears on entry to ACCESS and increments on every ACCESS cycle where pready = 0.
  - When the counter equals TIMEOUT and pready is still 0: go to IDLE, clear psel and penable, and pulse rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - cmd_ready = 0 on that edge; no chaining after a timeout.
- **Simultaneous events:** if pready = 1 arrives on the same edge the counter would expire, normal completion wins and rsp_timeout = 0.
- **Response path** has no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.

## Timing
- **Reset values**
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot: 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout: 0.
  - State: IDLE.
- **Reset mid-transfer:** outputs return to reset values asynchronously, the in-flight command is discarded and no response is generated.
- **Zero-wait transfer**
  - Command accepted at edge E0.
  - SETUP spans E0–E1; ACCESS spans E1–E2.
  - pready sampled high at E2; rsp_valid is high E2–E3.
  - Total latency: 2 cycles from acceptance to rsp_valid.
- **N wait states:** rsp_valid asserts N cycles later than the zero-wait case.
- **Chained transfers:** psel stays high continuously; penable is low for exactly one cycle between transfers. Steady-state throughput is one transfer every 2 cycles.
- **Timeout:** rsp_valid rises TIMEOUT+1 edges after entering ACCESS (E1).

## Test plan
- **Reset:** assert presetn = 0 mid-ACCESS -> psel = penable = 0 immediately, no rsp_valid, next command accepted normally after release.
- **Write, zero wait:** write 0xA5A5_1234 to 0x0000_0010, strb 0xF, prot 0x2, pready tied 1 -> SETUP psel=1 penable=0, ACCESS one cycle, rsp_valid 2 cycles after accept, rsp_err = 0.
- **Read, 3 wait states:** read 0x0000_0004, pready low 3 ACCESS cycles then high with prdata 0xDEAD_BEEF -> APB signals stable all 4 ACCESS cycles, rsp_rdata = 0xDEAD_BEEF, latency 5 cycles.
- **Slave error:** read 0x0000_0008, pslverr = 1 with pready -> rsp_err = 1, rsp_timeout = 0.
- **Back-to-back:** cmd_valid held for writes to 0x0, 0x4, 0x8, pready = 1 -> psel never drops, penable low one cycle between transfers, three rsp_valid pulses 2 cycles apart.
- **Timeout:** TIMEOUT = 4, pready held 0 -> abort 5 edges after ACCESS entry, rsp_err = rsp_timeout = 1, rsp_rdata = 0, psel = 0; pready = 1 on the fourth-count edge instead -> normal completion.

Source files
------------

// File: rtl/apb_requester_if.sv
// Command/response handshake and APB bus of the requester.
// master is the requester view; slave is the command source plus APB completer view.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: command/response handshake in, APB transfers out,
// with wait states, PSLVERR capture, back-to-back chaining and an ACCESS-phase timeout.
//
// state    | meaning
// S_IDLE   | no transfer; psel=0, command accepted when presented
// S_SETUP  | psel=1 penable=0 for exactly one cycle
// S_ACCESS | psel=1 penable=1 until pready, or until the timeout expires
module apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_requester_if.master bus
);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);
  localparam bit         TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                state;
  logic [7:0]            tmo_cnt;

  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic [2:0]            pprot_q;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic                  cmd_ready_c;
  logic                  cmd_fire;
  logic                  tmo_hit;

  // Ready in ACCESS follows pready so a new command can be taken on the completion edge.
  assign cmd_ready_c = presetn && ((state == S_IDLE) || ((state == S_ACCESS) && bus.pready));
  assign cmd_fire    = bus.cmd_valid && cmd_ready_c;
  // The timer counts down from TIMEOUT; pready on the expiry edge still completes normally.
  assign tmo_hit     = TMO_EN && (state == S_ACCESS) && !bus.pready && (tmo_cnt == 8'd0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= S_IDLE;
      tmo_cnt       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;

      if (cmd_fire) begin
        paddr_q  <= bus.cmd_addr;
        pwrite_q <= bus.cmd_write;
        pprot_q  <= bus.cmd_prot;
        pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
        pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            state     <= S_SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
          end
        end

        S_SETUP: begin
          state     <= S_ACCESS;
          penable_q <= 1'b1;
          tmo_cnt   <= TMO_LOAD;
        end

        S_ACCESS: begin
          if (bus.pready) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (cmd_fire) begin
              state <= S_SETUP;
            end else begin
              state  <= S_IDLE;
              psel_q <= 1'b0;
            end
          end else if (tmo_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state         <= S_IDLE;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed and random transfer plans checked cycle by cycle
// against a transaction-level timing model (fire edge, wait count, response edge).
module tb_apb_requester;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int TMO    = 4;
  localparam int BUDGET = 3000;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  apb_requester #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STRB_WIDTH(SW),
    .TIMEOUT   (TMO)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
    int            gap;
    bit            kill;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            due;
  } rsp_t;

  plan_t         plans[$];
  rsp_t          rsp_q[$];
  plan_t         cur;
  bit            cur_v = 1'b0;
  bit            cur_tmo = 1'b0;
  int            cur_f = 0;
  int            cur_r = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          last_tmo = 1'b0;
  int            cyc = 0;
  int            gap_cnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic plan_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb, input logic [2:0] prot,
                               input logic [DW-1:0] rdata, input logic err, input int waits,
                               input int gap, input bit kill);
    plan_t p;
    p.wr = wr; p.addr = addr; p.wdata = wdata; p.strb = strb; p.prot = prot;
    p.rdata = rdata; p.err = err; p.waits = waits; p.gap = gap; p.kill = kill;
    return p;
  endfunction

  function automatic plan_t rnd_plan();
    int g;
    g = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    return mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom), 3'($urandom),
              DW'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), g, 1'b0);
  endfunction

  // A transfer fired at edge F owns the bus for cycles F..R-1; R is its response cycle.
  function automatic bit active();
    return cur_v && (cyc >= cur_f) && (cyc < cur_r);
  endfunction

  initial begin
    bit    act;
    bit    exp_rv;
    bit    exp_rdy;
    plan_t p;
    rsp_t  r;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0055;
    bus.cmd_wdata = 32'h1234_5678;
    bus.cmd_strb  = 4'hF;
    bus.cmd_prot  = 3'h7;
    bus.pready    = 1'b1;
    bus.prdata    = 32'hFFFF_FFFF;
    bus.pslverr   = 1'b1;
    repeat (2) @(negedge pclk);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_pstrb", bus.pstrb, 0);
    check("rst_pprot", bus.pprot, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);

    plans.push_back(mk(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'h2, 32'h0,         1'b0, 0,  1, 1'b0));
    plans.push_back(mk(1'b0, 32'h04, 32'h1357_9BDF, 4'hF, 3'h0, 32'hDEAD_BEEF, 1'b0, 3,  2, 1'b0));
    plans.push_back(mk(1'b0, 32'h08, 32'h0,         4'h0, 3'h1, 32'h5555_AAAA, 1'b1, 0,  1, 1'b0));
    plans.push_back(mk(1'b1, 32'h00, 32'h1111_1111, 4'hF, 3'h0, 32'h0,         1'b0, 0,  1, 1'b0));
    plans.push_back(mk(1'b1, 32'h04, 32'h2222_2222, 4'h3, 3'h0, 32'h0,         1'b0, 0,  0, 1'b0));
    plans.push_back(mk(1'b1, 32'h08, 32'h3333_3333, 4'hC, 3'h0, 32'h0,         1'b0, 0,  0, 1'b0));
    plans.push_back(mk(1'b0, 32'h20, 32'h0,         4'h0, 3'h4, 32'hCAFE_F00D, 1'b0, 20, 2, 1'b0));
    plans.push_back(mk(1'b0, 32'h24, 32'h0,         4'h0, 3'h0, 32'h600D_F00D, 1'b0, TMO, 0, 1'b0));
    plans.push_back(mk(1'b1, 32'h28, 32'h4444_4444, 4'hF, 3'h0, 32'h0,         1'b1, TMO + 1, 0, 1'b0));
    plans.push_back(mk(1'b0, 32'h30, 32'h0,         4'h0, 3'h0, 32'h7777_7777, 1'b0, 6,  1, 1'b1));
    plans.push_back(mk(1'b1, 32'h34, 32'h8888_8888, 4'h5, 3'h3, 32'h0,         1'b0, 1,  0, 1'b0));
    for (int i = 0; i < 80; i++) plans.push_back(rnd_plan());

    gap_cnt = plans[0].gap;
    presetn = 1'b1;

    while (cyc < BUDGET && (plans.size() != 0 || rsp_q.size() != 0)) begin
      act = active();
      check("psel", bus.psel, act);
      check("penable", bus.penable, act && (cyc > cur_f));
      if (act) begin
        check("paddr", bus.paddr, cur.addr);
        check("pwrite", bus.pwrite, cur.wr);
        check("pwdata", bus.pwdata, cur.wr ? cur.wdata : '0);
        check("pstrb", bus.pstrb, cur.wr ? cur.strb : '0);
        check("pprot", bus.pprot, cur.prot);
      end
      exp_rv = (rsp_q.size() != 0) && (rsp_q[0].due == cyc);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        r = rsp_q.pop_front();
        last_rdata = r.rdata;
        last_err   = r.err;
        last_tmo   = r.tmo;
      end
      check("rsp_rdata", bus.rsp_rdata, last_rdata);
      check("rsp_err", bus.rsp_err, last_err);
      check("rsp_timeout", bus.rsp_timeout, last_tmo);

      if (act && cur.kill && (cyc == cur_f + 2)) begin
        presetn = 1'b0;
        #1;
        check("arst_psel", bus.psel, 0);
        check("arst_penable", bus.penable, 0);
        check("arst_paddr", bus.paddr, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_cmd_ready", bus.cmd_ready, 0);
        cur_v = 1'b0;
        rsp_q.delete();
        last_rdata = '0;
        last_err   = 1'b0;
        last_tmo   = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        @(posedge pclk);
        cyc++;
        @(negedge pclk);
        check("arst_hold_psel", bus.psel, 0);
        presetn = 1'b1;
        continue;
      end

      // Completer: pready low through the planned wait cycles, random outside ACCESS.
      if (act && (cyc == cur_f + 1 + cur.waits)) begin
        bus.pready  = 1'b1;
        bus.prdata  = cur.rdata;
        bus.pslverr = cur.err;
      end else begin
        bus.pready  = (act && (cyc > cur_f)) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.prdata  = DW'($urandom);
        bus.pslverr = 1'($urandom_range(0, 1));
      end

      if (plans.size() != 0 && gap_cnt == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = plans[0].wr;
        bus.cmd_addr  = plans[0].addr;
        bus.cmd_wdata = plans[0].wdata;
        bus.cmd_strb  = plans[0].strb;
        bus.cmd_prot  = plans[0].prot;
      end else begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
        bus.cmd_strb  = SW'($urandom);
        bus.cmd_prot  = 3'($urandom);
        if (gap_cnt > 0) gap_cnt--;
      end

      #1;
      exp_rdy = !act || ((cyc == cur_r - 1) && !cur_tmo);
      check("cmd_ready", bus.cmd_ready, exp_rdy);
      if (bus.cmd_valid && exp_rdy) begin
        p       = plans.pop_front();
        cur     = p;
        cur_v   = 1'b1;
        cur_f   = cyc + 1;
        cur_tmo = (TMO != 0) && (p.waits > TMO);
        cur_r   = cur_f + (cur_tmo ? TMO + 2 : p.waits + 2);
        if (!p.kill) begin
          r.rdata = (cur_tmo || p.wr) ? '0 : p.rdata;
          r.err   = cur_tmo ? 1'b1 : p.err;
          r.tmo   = cur_tmo;
          r.due   = cur_r;
          rsp_q.push_back(r);
        end
        gap_cnt = (plans.size() != 0) ? plans[0].gap : 0;
      end

      @(posedge pclk);
      cyc++;
      @(negedge pclk);
    end

    check("drain", plans.size() + rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
